// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of 2-bit counters, tags and targets.
// Predicts at fetch with a registered one-cycle result; trained from execute.
module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 16
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic            upd_is_b_type_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            flush_i
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             u_hit;
    logic             upd_en;
    logic [1:0]       ctr_d;

    logic            pred_valid_q;
    logic            pred_valid_d;
    logic            pred_taken_q;
    logic            pred_taken_d;
    logic [XLEN-1:0] pred_target_q;
    logic [XLEN-1:0] pred_target_d;

    assign f_idx  = fetch_pc_i[2 +: IDX_W];
    assign f_tag  = fetch_pc_i[2+IDX_W +: TAG_W];
    assign u_idx  = upd_pc_i[2 +: IDX_W];
    assign u_tag  = upd_pc_i[2+IDX_W +: TAG_W];
    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // A flush in the same cycle drops the update entirely.
    assign upd_en = upd_valid_i && upd_is_b_type_i && !flush_i;

    always_comb begin
        ctr_d = ctr_q[u_idx];
        if (u_hit) begin
            if (upd_taken_i) begin
                if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
            end else begin
                if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
            end
        end else if (upd_taken_i) begin
            ctr_d = 2'b10;
        end
    end

    always_comb begin
        pred_valid_d  = fetch_valid_i;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (fetch_valid_i) begin
            pred_taken_d  = f_hit && ctr_q[f_idx][1];
            pred_target_d = pred_taken_d ? tgt_q[f_idx]
                                         : fetch_pc_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (upd_en && (u_hit || upd_taken_i)) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_d;
        end
    end

    // Tag/target need no reset: every read is qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (upd_en && upd_taken_i) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors, expected predictions queued
// at issue and checked by a monitor whenever pred_valid_o is high.
module tb_branch_predictor;
    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        fetch_valid_i;
    logic [63:0] fetch_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [63:0] pred_target_o;
    logic        upd_valid_i;
    logic        upd_is_b_type_i;
    logic [63:0] upd_pc_i;
    logic        upd_taken_i;
    logic [63:0] upd_target_i;
    logic        flush_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q [$];

    branch_predictor #(.XLEN(64), .ENTRIES(64), .TAG_W(16)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i(upd_valid_i), .upd_is_b_type_i(upd_is_b_type_i),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid prediction must match the oldest queued one.
    always @(negedge clk_i) begin
        if (resetn_i && pred_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pred: got valid 1 expected none");
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("pred_taken", 64'(pred_taken_o), 64'(e[64]));
                check("pred_target", pred_target_o, e[63:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        fetch_valid_i   = 1'b0;
        upd_valid_i     = 1'b0;
        upd_is_b_type_i = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic set_fetch(input logic [63:0] pc, input logic t,
                             input logic [63:0] tgt);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        exp_q.push_back({t, tgt});
    endtask

    task automatic set_upd(input logic [63:0] pc, input logic t,
                           input logic [63:0] tgt);
        upd_valid_i     = 1'b1;
        upd_is_b_type_i = 1'b1;
        upd_pc_i        = pc;
        upd_taken_i     = t;
        upd_target_i    = tgt;
    endtask

    task automatic fetch(input logic [63:0] pc, input logic t,
                         input logic [63:0] tgt);
        set_fetch(pc, t, tgt);
        tick();
    endtask

    task automatic upd(input logic [63:0] pc, input logic t,
                       input logic [63:0] tgt);
        set_upd(pc, t, tgt);
        tick();
    endtask

    initial begin
        resetn_i        = 1'b0;
        fetch_valid_i   = 1'b0;
        fetch_pc_i      = '0;
        upd_valid_i     = 1'b0;
        upd_is_b_type_i = 1'b0;
        upd_pc_i        = '0;
        upd_taken_i     = 1'b0;
        upd_target_i    = '0;
        flush_i         = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(pred_valid_o), 64'd0);
        check("rst_taken", 64'(pred_taken_o), 64'd0);
        check("rst_target", pred_target_o, 64'd0);
        resetn_i = 1'b1;
        tick();

        // Cold lookup
        fetch(64'h1000, 1'b0, 64'h1004);
        // Allocate, predict, then train down
        upd(64'h1000, 1'b1, 64'h0F00);
        fetch(64'h1000, 1'b1, 64'h0F00);
        tick();
        check("idle_valid", 64'(pred_valid_o), 64'd0);
        check("idle_taken_hold", 64'(pred_taken_o), 64'd1);
        check("idle_tgt_hold", pred_target_o, 64'h0F00);
        upd(64'h1000, 1'b0, 64'h0);
        upd(64'h1000, 1'b0, 64'h0);
        fetch(64'h1000, 1'b0, 64'h1004);

        // Saturation at 11, then down to 00
        repeat (4) upd(64'h1000, 1'b1, 64'h0F00);
        upd(64'h1000, 1'b0, 64'h0);
        fetch(64'h1000, 1'b1, 64'h0F00);
        repeat (3) upd(64'h1000, 1'b0, 64'h0);
        fetch(64'h1000, 1'b0, 64'h1004);

        // Aliasing on index 0
        repeat (2) upd(64'h1000, 1'b1, 64'h0F00);
        fetch(64'h1000, 1'b1, 64'h0F00);
        fetch(64'h1100, 1'b0, 64'h1104);
        upd(64'h1100, 1'b1, 64'h3000);
        fetch(64'h1100, 1'b1, 64'h3000);
        fetch(64'h1000, 1'b0, 64'h1004);

        // Read-before-write on same index
        set_fetch(64'h2000, 1'b0, 64'h2004);
        set_upd(64'h2000, 1'b1, 64'h2400);
        tick();
        fetch(64'h2000, 1'b1, 64'h2400);

        // Flush beats update; lookup sees pre-flush state
        set_fetch(64'h2000, 1'b1, 64'h2400);
        set_upd(64'h3004, 1'b1, 64'h5000);
        flush_i = 1'b1;
        tick();
        fetch(64'h2000, 1'b0, 64'h2004);
        fetch(64'h3004, 1'b0, 64'h3008);
        upd(64'h2000, 1'b0, 64'h0);
        fetch(64'h2000, 1'b0, 64'h2004);
        upd(64'h2000, 1'b1, 64'h2400);
        fetch(64'h2000, 1'b1, 64'h2400);

        // Non-B-type update is ignored
        upd_valid_i  = 1'b1;
        upd_pc_i     = 64'h3004;
        upd_taken_i  = 1'b1;
        upd_target_i = 64'h5000;
        tick();
        fetch(64'h3004, 1'b0, 64'h3008);

        // Async reset while a prediction is presented
        fetch(64'h2000, 1'b1, 64'h2400);
        @(negedge clk_i);
        #1;
        check("pre_rst_valid", 64'(pred_valid_o), 64'd1);
        resetn_i = 1'b0;
        #1;
        check("async_valid", 64'(pred_valid_o), 64'd0);
        check("async_taken", 64'(pred_taken_o), 64'd0);
        check("async_target", pred_target_o, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        tick();
        fetch(64'h2000, 1'b0, 64'h2004);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
